// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin controller sharing one sequential divider among N_REQ requesters.
// Divide-by-zero is answered locally (quotient all ones, remainder = dividend) without starting the divider.
module div_share_ctrl #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int DIV_LAT = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_dividend,
    input  logic [N_REQ*WIDTH-1:0]   req_divisor,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_quotient,
    output logic [WIDTH-1:0]         rsp_remainder,
    output logic                     rsp_dz,
    output logic                     busy,
    output logic                     div_ready,
    output logic [WIDTH-1:0]         div_dividend,
    output logic [WIDTH-1:0]         div_divisor,
    input  logic [WIDTH-1:0]         div_quotient,
    input  logic [WIDTH-1:0]         div_reminder
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(DIV_LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, owner, sel, cand;
    logic [CW-1:0]    cnt;
    logic             found, take, run_end;
    logic [WIDTH-1:0] sel_dividend, sel_divisor;

    // Later iterations override earlier ones, so the smallest offset from ptr wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign sel_dividend = req_dividend[sel*WIDTH +: WIDTH];
    assign sel_divisor  = req_divisor[sel*WIDTH +: WIDTH];
    assign take         = rst_n && (state == IDLE) && found;
    assign run_end      = (state == RUN) && (cnt == CW'(DIV_LAT - 1));

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? (found ? ((sel_divisor == '0) ? DONE : LOAD) : IDLE) :
                    (state == LOAD) ? RUN :
                    (state == RUN)  ? (run_end ? DONE : RUN) : IDLE;
    end

    assign gnt       = take ? (N_REQ'(1) << sel) : '0;
    assign rsp_valid = (state == DONE) ? (N_REQ'(1) << owner) : '0;
    assign busy      = (state != IDLE);
    assign div_ready = (state == LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            owner         <= '0;
            cnt           <= '0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            rsp_dz        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                ptr          <= (sel == PW'(N_REQ - 1)) ? '0 : sel + PW'(1);
                owner        <= sel;
                div_dividend <= sel_dividend;
                div_divisor  <= sel_divisor;
                if (sel_divisor == '0) begin
                    rsp_quotient  <= '1;
                    rsp_remainder <= sel_dividend;
                    rsp_dz        <= 1'b1;
                end
            end
            if (state == LOAD)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + CW'(1);
            if (run_end) begin
                rsp_quotient  <= div_quotient;
                rsp_remainder <= div_reminder;
                rsp_dz        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed bench for div_share_ctrl with a behavioural fixed-latency divider.
module tb_div_share_ctrl;
    localparam int N = 4;
    localparam int W = 8;
    localparam int LAT = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_dividend = '0;
    logic [N*W-1:0] req_divisor = '0;
    logic [N-1:0]   gnt, rsp_valid;
    logic [W-1:0]   rsp_quotient, rsp_remainder, div_dividend, div_divisor;
    logic [W-1:0]   div_quotient = '0;
    logic [W-1:0]   div_reminder = '0;
    logic           rsp_dz, busy, div_ready;
    int             checks = 0;
    int             errors = 0;

    div_share_ctrl #(.N_REQ(N), .WIDTH(W), .DIV_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_dz(rsp_dz), .busy(busy), .div_ready(div_ready), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_quotient(div_quotient), .div_reminder(div_reminder)
    );

    always #5 clk = ~clk;

    // Divider model: outputs hold garbage until LAT cycles after the start strobe.
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = 8'd1;
    int           left = 0;
    always @(posedge clk) begin
        if (div_ready) begin
            op_a         <= div_dividend;
            op_b         <= div_divisor;
            left         <= LAT - 1;
            div_quotient <= 8'h5A;
            div_reminder <= 8'hA5;
        end else if (left > 0) begin
            left <= left - 1;
            if (left == 1) begin
                div_quotient <= op_a / op_b;
                div_reminder <= op_a % op_b;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt == '0 && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("idle_timeout", busy, 0);
    endtask

    task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] q, input logic [7:0] r, input logic dz);
        int n, lat, rdy;
        req_dividend[i*W +: W] = a;
        req_divisor[i*W +: W]  = b;
        req[i] = 1'b1;
        #1;
        wait_gnt(n);
        check("gnt", gnt, 32'(1 << i));
        @(negedge clk);
        req[i] = 1'b0;
        #1;
        check("ready_t1", div_ready, 32'(!dz));
        check("busy_t1", busy, 1);
        lat = 1;
        rdy = div_ready;
        while (rsp_valid == '0 && lat < 40) begin
            @(negedge clk);
            #1;
            lat++;
            rdy += div_ready;
        end
        check("latency", lat, dz ? 1 : LAT + 2);
        check("rsp_owner", rsp_valid, 32'(1 << i));
        check("quotient", rsp_quotient, q);
        check("remainder", rsp_remainder, r);
        check("dz", rsp_dz, dz);
        check("ready_count", rdy, dz ? 0 : 1);
        check("div_divisor", div_divisor, b);
        @(negedge clk);
        #1;
        check("rsp_pulse", rsp_valid, 0);
        check("busy_idle", busy, 0);
        check("rsp_hold_q", rsp_quotient, q);
    endtask

    initial begin
        int order[6] = '{0, 1, 2, 3, 0, 1};
        logic [7:0] ta[4] = '{8'd100, 8'd77, 8'd250, 8'd9};
        logic [7:0] tb[4] = '{8'd7, 8'd3, 8'd16, 8'd2};
        logic [7:0] tq[4] = '{8'd14, 8'd25, 8'd15, 8'd4};
        logic [7:0] tr[4] = '{8'd2, 8'd2, 8'd10, 8'd1};
        int ng = 0, nrsp = 0, last = 0, n = 0, bad = 0;

        // Reset with every requester already asking
        for (int k = 0; k < N; k++) begin
            req_dividend[k*W +: W] = ta[k];
            req_divisor[k*W +: W]  = tb[k];
        end
        req = '1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ready", div_ready, 0);
        check("rst_q", rsp_quotient, 0);
        check("rst_r", rsp_remainder, 0);
        check("rst_dz", rsp_dz, 0);
        check("rst_div_a", div_dividend, 0);
        check("rst_div_b", div_divisor, 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 150; c++) begin
            #1;
            if (gnt != '0 && ng < 6) begin
                check("rr_gnt", gnt, 32'(1 << order[ng]));
                if (ng > 0) check("rr_gap", c - last, LAT + 3);
                last = c;
                ng++;
            end
            if (rsp_valid != '0 && nrsp < 6) begin
                check("rr_rsp_owner", rsp_valid, 32'(1 << order[nrsp]));
                check("rr_q", rsp_quotient, tq[order[nrsp]]);
                check("rr_r", rsp_remainder, tr[order[nrsp]]);
                nrsp++;
            end
            if (ng == 6 && req == '0 && !busy) break;
            @(negedge clk);
            if (ng == 6) req = '0;
        end
        check("rr_grants", ng, 6);
        check("rr_rsps", nrsp, 6);

        run_op(0, 8'd133, 8'd17, 8'd7, 8'd14, 1'b0);
        run_op(1, 8'd200, 8'd0, 8'hFF, 8'd200, 1'b1);
        run_op(2, 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);

        // Pointer now 3: requester 3 must beat requester 0
        req_dividend[0*W +: W] = 8'd20;
        req_divisor[0*W +: W]  = 8'd4;
        req_dividend[3*W +: W] = 8'd30;
        req_divisor[3*W +: W]  = 8'd5;
        req[0] = 1'b1;
        req[3] = 1'b1;
        #1;
        wait_gnt(n);
        check("wrap_first", gnt, 32'b1000);
        @(negedge clk);
        req[3] = 1'b0;
        #1;
        wait_gnt(n);
        check("wrap_second", gnt, 32'b0001);
        check("wrap_gap", n + 1, LAT + 3);
        check("wrap_rsp_q", rsp_quotient, 8'd6);
        @(negedge clk);
        req[0] = 1'b0;
        #1;
        wait_idle();

        run_op(1, 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        run_op(0, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);

        // Reset five cycles after a grant, while the divider is running
        req_dividend[2*W +: W] = 8'd100;
        req_divisor[2*W +: W]  = 8'd3;
        req[2] = 1'b1;
        #1;
        wait_gnt(n);
        check("mid_gnt", gnt, 32'b0100);
        @(negedge clk);
        req[2] = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_ready", div_ready, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_q", rsp_quotient, 0);
        check("mid_r", rsp_remainder, 0);
        check("mid_div_a", div_dividend, 0);
        check("mid_div_b", div_divisor, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rsp_valid != '0 || busy || div_ready) bad++;
            @(negedge clk);
        end
        check("mid_no_rsp", bad, 0);
        run_op(3, 8'd50, 8'd7, 8'd7, 8'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
